// File: rtl/mult_iter_if.sv
// Operand/result handshake bundle for the iterative multiplier.
interface mult_iter_if #(
    parameter int W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic             sgn;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   p;

    modport master (
        output in_valid, x, y, sgn, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, x, y, sgn, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/mult_iter.sv
// Iterative shift-add multiplier retiring BPC multiplier bits per cycle,
// signed (two's complement) or unsigned, with a valid/ready handshake.
module mult_iter #(
    parameter int W   = 8,
    parameter int BPC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    mult_iter_if.slave bus
);
    localparam int N  = W / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((W < 2) || (BPC < 1) || ((W % BPC) != 0)) begin : g_bad_cfg
            $error("mult_iter: illegal W/BPC configuration");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic             sgn_q, sgn_d;
    logic [2*W-1:0]   p_q, p_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [2*W-1:0]   sum_s;
    logic [2*W-1:0]   term_s;
    logic             last_s;

    assign last_s = (cnt_q == CW'(N - 1));

    // Partial sum for this cycle; in signed mode the multiplier MSB carries negative weight.
    always_comb begin
        sum_s  = acc_q;
        term_s = '0;
        for (int j = 0; j < BPC; j++) begin
            term_s = mcand_q << j;
            if (mplier_q[j]) begin
                if (sgn_q && last_s && (j == BPC - 1)) begin
                    sum_s = sum_s - term_s;
                end else begin
                    sum_s = sum_s + term_s;
                end
            end else begin
                sum_s = sum_s;
            end
        end
    end

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        sgn_d       = sgn_q;
        p_d         = p_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    acc_d      = '0;
                    mcand_d    = {{W{bus.sgn & bus.x[W-1]}}, bus.x};
                    mplier_d   = bus.y;
                    sgn_d      = bus.sgn;
                    in_ready_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d    = sum_s;
                mcand_d  = mcand_q << BPC;
                mplier_d = mplier_q >> BPC;
                if (last_s) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    p_d         = sum_s;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // Consumption returns to IDLE; acceptance is only possible from the next cycle.
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            sgn_q       <= 1'b0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            sgn_q       <= sgn_d;
            p_q         <= p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
endmodule

// File: tb/tb_mult_iter.sv
// Directed self-checking bench for mult_iter (W=8, BPC=2).
module tb_mult_iter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [15:0] prev_p;

    mult_iter_if #(.W(8)) bus ();

    mult_iter #(.W(8), .BPC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, scramble inputs, measure latency, hold for `hold` cycles, consume.
    task automatic run_op(input string tag, input logic s, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp, input int hold);
        int lat;
        bit stable;
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.sgn      = s;
        bus.x        = a;
        bus.y        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.x   = ~a;
        bus.y   = b ^ 8'h5A;
        bus.sgn = ~s;
        lat     = 0;
        stable  = 1'b1;
        do begin
            if (bus.p !== prev_p || bus.in_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 20);
        chk({tag, "_latency"}, lat, 32'd4);
        chk({tag, "_p"}, {16'd0, bus.p}, {16'd0, exp});
        chk({tag, "_run_quiet"}, {31'd0, stable}, 32'd1);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus.in_valid = ~bus.in_valid;
            if (bus.out_valid !== 1'b1 || bus.p !== exp || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold"}, {31'd0, stable}, 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({tag, "_drop_valid"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        chk({tag, "_p_kept"}, {16'd0, bus.p}, {16'd0, exp});
        prev_p = exp;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        prev_p        = 16'h0000;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = 8'h00;
        bus.y         = 8'h00;
        bus.sgn       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {14'd0, bus.in_ready, bus.out_valid, bus.p}, {14'd0, 2'b10, 16'h0000});
        rst_n = 1'b1;

        run_op("umax",      1'b0, 8'hFF, 8'hFF, 16'hFE01, 0);
        run_op("smin",      1'b1, 8'h80, 8'h80, 16'h4000, 0);
        run_op("smixed",    1'b1, 8'hFF, 8'h7F, 16'hFF81, 6);
        run_op("u80xFF",    1'b0, 8'h80, 8'hFF, 16'h7F80, 0);
        run_op("s80xFF",    1'b1, 8'h80, 8'hFF, 16'h0080, 0);
        run_op("zero_x",    1'b0, 8'h00, 8'h5A, 16'h0000, 0);
        run_op("szero_y",   1'b1, 8'h81, 8'h00, 16'h0000, 0);
        run_op("s7Fx7F",    1'b1, 8'h7F, 8'h7F, 16'h3F01, 0);
        run_op("s81x02",    1'b1, 8'h81, 8'h02, 16'hFF02, 2);
        run_op("uFFx01",    1'b0, 8'hFF, 8'h01, 16'h00FF, 0);

        // Reset lands on the second RUN cycle of an operation that must never complete.
        bus.sgn      = 1'b0;
        bus.x        = 8'h12;
        bus.y        = 8'h34;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrun_reset", {14'd0, bus.in_ready, bus.out_valid, bus.p}, {14'd0, 2'b10, 16'h0000});
        prev_p = 16'h0000;
        rst_n  = 1'b1;
        run_op("after_reset", 1'b0, 8'h03, 8'h05, 16'h000F, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
